// File: rtl/cpu_pkg.sv
// Shared RV32I-subset decode constants, ALU/write-back enums and 7-segment patterns.
// Imported by cpu and seven_seg_decoder; no ports.
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] SENTINEL = 32'h7FFF_FFFF;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4
  } wb_sel_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // alt selects SUB/SRA; callers pass it only where it applies
  function automatic alu_op_e f3_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    case (f3)
      F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-BCD blanks.
// Ports: digit (4b in), seg (7b out).
module seven_seg_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I-subset CPU with hard-coded ROM, data RAM and BCD/7-seg view.
// Ports: clk, rst (async high); finalOut, instr, currentPC; BCD digits and
// 7-seg patterns of finalOut. Macro CPU_HALT_SENTINEL_EN freezes PC on SENTINEL.
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned ROM_DEPTH  = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] finalOut,
  output logic [31:0] instr,
  output logic [31:0] currentPC,
  output logic [3:0]  thousands,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic [6:0]  displayOnes,
  output logic [6:0]  displayTens,
  output logic [6:0]  displayHundreds,
  output logic [6:0]  displayThousands
);

  // DMEM_DEPTH is a power of two, so modulo is a bit slice
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic [31:0] rom_word;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] op_a, op_b, alu_res, pc4;
  logic [31:0] mem_rdata, wb_data;
  logic [DAW-1:0] dmem_idx;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        rf_we, mem_we;
  logic        is_br, is_jal, is_jalr, br_taken;
  logic [13:0] bcd_v;

  always_comb begin
    case (pc_q[31:2])
      30'd0:   rom_word = 32'h0050_0093;
      30'd1:   rom_word = 32'h0070_0113;
      30'd2:   rom_word = 32'h0020_81B3;
      30'd3:   rom_word = 32'h4011_0233;
      30'd4:   rom_word = 32'h0030_2023;
      30'd5:   rom_word = 32'h0000_2283;
      30'd6:   rom_word = 32'h0032_8463;
      30'd7:   rom_word = 32'h0630_0313;
      30'd8:   rom_word = 32'h0000_13B7;
      30'd9:   rom_word = 32'h4D23_8413;
      default: rom_word = SENTINEL;
    endcase
    instr = ({2'b00, pc_q[31:2]} < ROM_DEPTH) ? rom_word : SENTINEL;
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  always_comb begin
    alu_op  = ALU_ADD;
    op_a    = rs1_val;
    op_b    = imm_i;
    wb_sel  = WB_ALU;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    case (opcode)
      OP_R: begin
        if (f7 == F7_ZERO ||
            (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
          alu_op = f3_alu(f3, f7[5]);
          op_b   = rs2_val;
          rf_we  = 1'b1;
        end
      end
      OP_I: begin
        // SLTIU is outside the supported subset
        if (f3 != F3_SLTU &&
            (f3 == F3_SLL ? f7 == F7_ZERO :
             (f3 != F3_SR || f7 == F7_ZERO || f7 == F7_ALT))) begin
          alu_op = f3_alu(f3, f3 == F3_SR && f7[5]);
          rf_we  = 1'b1;
        end
      end
      OP_LOAD: begin
        if (f3 == F3_W) begin
          wb_sel = WB_MEM;
          rf_we  = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == F3_W) begin
          op_b   = imm_s;
          mem_we = 1'b1;
        end
      end
      OP_BR: begin
        if (f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE}) begin
          alu_op = ALU_SUB;
          op_b   = rs2_val;
          is_br  = 1'b1;
        end
      end
      OP_JAL: begin
        op_a   = pc_q;
        op_b   = imm_j;
        wb_sel = WB_PC4;
        rf_we  = 1'b1;
        is_jal = 1'b1;
      end
      OP_JALR: begin
        if (f3 == 3'd0) begin
          wb_sel  = WB_PC4;
          rf_we   = 1'b1;
          is_jalr = 1'b1;
        end
      end
      OP_LUI: begin
        op_a  = 32'd0;
        op_b  = imm_u;
        rf_we = 1'b1;
      end
      OP_AUIPC: begin
        op_a  = pc_q;
        op_b  = imm_u;
        rf_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < op_b};
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      default:  alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      default: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
    endcase
  end

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc4;
    if (is_br && br_taken) pc_d = pc_q + imm_b;
    else if (is_jal)       pc_d = alu_res;
    else if (is_jalr)      pc_d = {alu_res[31:1], 1'b0};
`ifdef CPU_HALT_SENTINEL_EN
    if (instr == SENTINEL) pc_d = pc_q;
`else
`endif
  end

  assign dmem_idx  = alu_res[DAW+1:2];
  assign mem_rdata = dmem_q[dmem_idx];

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && rd != 5'd0) rf_q[rd] <= wb_data;
    end
  end

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) dmem_q[dmem_idx] <= rs2_val;
  end

  assign finalOut  = wb_data;
  assign currentPC = pc_q;

  always_comb begin
    bcd_v     = 14'(finalOut % 32'd10000);
    thousands = 4'(bcd_v / 14'd1000);
    hundreds  = 4'((bcd_v / 14'd100) % 14'd10);
    tens      = 4'((bcd_v / 14'd10) % 14'd10);
    ones      = 4'(bcd_v % 14'd10);
  end

  seven_seg_decoder u_seg_ones (.digit(ones),      .seg(displayOnes));
  seven_seg_decoder u_seg_tens (.digit(tens),      .seg(displayTens));
  seven_seg_decoder u_seg_hund (.digit(hundreds),  .seg(displayHundreds));
  seven_seg_decoder u_seg_thou (.digit(thousands), .seg(displayThousands));

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed vector table, sentinel/reset sequences
// and randomized reset/run lengths checked against a program-trace model.
module tb_cpu;

  localparam logic [31:0] SENT = 32'h7FFF_FFFF;
  localparam logic [31:0] ROM0 = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] final_out, instr, current_pc;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [6:0]  d_ones, d_tens, d_hund, d_thou;

  cpu dut (
    .clk(clk), .rst(rst),
    .finalOut(final_out), .instr(instr), .currentPC(current_pc),
    .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones),
    .displayOnes(d_ones), .displayTens(d_tens),
    .displayHundreds(d_hund), .displayThousands(d_thou)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n;

  // Program trace: what the listed program does, step by step after reset
  logic [31:0] tr_pc [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                             32'h14, 32'h18, 32'h20, 32'h24};
  logic [31:0] tr_ins [9] = '{32'h0050_0093, 32'h0070_0113,
                              32'h0020_81B3, 32'h4011_0233,
                              32'h0030_2023, 32'h0000_2283,
                              32'h0032_8463, 32'h0000_13B7,
                              32'h4D23_8413};
  logic [31:0] tr_out [9] = '{32'd5, 32'd7, 32'd12, 32'd2, 32'd0,
                              32'd12, 32'd0, 32'd4096, 32'd5330};

  function automatic logic [31:0] exp_pc(int s);
    if (s < 9) return tr_pc[s];
`ifdef CPU_HALT_SENTINEL_EN
    return 32'h28;
`else
    return 32'h28 + 32'(4 * (s - 9));
`endif
  endfunction

  function automatic logic [31:0] exp_ins(int s);
    if (s < 9) return tr_ins[s];
    return SENT;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_disp(logic [31:0] f);
    int v;
    v = int'(f % 32'd10000);
    chk("thousands", 32'(thousands), 32'(v / 1000));
    chk("hundreds", 32'(hundreds), 32'((v / 100) % 10));
    chk("tens", 32'(tens), 32'((v / 10) % 10));
    chk("ones", 32'(ones), 32'(v % 10));
    chk("seg_thou", 32'(d_thou), 32'(seg_of(v / 1000)));
    chk("seg_hund", 32'(d_hund), 32'(seg_of((v / 100) % 10)));
    chk("seg_tens", 32'(d_tens), 32'(seg_of((v / 10) % 10)));
    chk("seg_ones", 32'(d_ones), 32'(seg_of(v % 10)));
  endtask

  task automatic check_step(int s);
    chk("pc", current_pc, exp_pc(s));
    chk("instr", instr, exp_ins(s));
    if (s < 9) begin
      chk("final", final_out, tr_out[s]);
      check_disp(tr_out[s]);
    end
  endtask

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic [31:0] fout;
    logic [3:0]  th, hu, te, on;
    logic [6:0]  seg_on, seg_th;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int unsigned len, hold;

    vecs[0] = '{0, 32'h00, 32'd5,    4'd0, 4'd0, 4'd0, 4'd5,
                7'b0010010, 7'b1000000};
    vecs[1] = '{1, 32'h04, 32'd7,    4'd0, 4'd0, 4'd0, 4'd7,
                7'b1111000, 7'b1000000};
    vecs[2] = '{2, 32'h08, 32'd12,   4'd0, 4'd0, 4'd1, 4'd2,
                7'b0100100, 7'b1000000};
    vecs[3] = '{3, 32'h0C, 32'd2,    4'd0, 4'd0, 4'd0, 4'd2,
                7'b0100100, 7'b1000000};
    vecs[4] = '{4, 32'h10, 32'd0,    4'd0, 4'd0, 4'd0, 4'd0,
                7'b1000000, 7'b1000000};
    vecs[5] = '{5, 32'h14, 32'd12,   4'd0, 4'd0, 4'd1, 4'd2,
                7'b0100100, 7'b1000000};
    vecs[6] = '{6, 32'h18, 32'd0,    4'd0, 4'd0, 4'd0, 4'd0,
                7'b1000000, 7'b1000000};
    vecs[7] = '{7, 32'h20, 32'd4096, 4'd4, 4'd0, 4'd9, 4'd6,
                7'b0000010, 7'b0011001};
    vecs[8] = '{8, 32'h24, 32'd5330, 4'd5, 4'd3, 4'd3, 4'd0,
                7'b1000000, 7'b0010010};

    // Held in reset: PC at start, first instruction visible
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_instr", instr, ROM0);
    chk("rst_final", final_out, 32'd5);
    rst = 1'b0;
    n = 0;
    #1;

    foreach (vecs[i]) begin
      while (n < vecs[i].step) begin
        @(negedge clk);
        n++;
      end
      chk("v_pc", current_pc, vecs[i].pc);
      chk("v_final", final_out, vecs[i].fout);
      chk("v_thou", 32'(thousands), 32'(vecs[i].th));
      chk("v_hund", 32'(hundreds), 32'(vecs[i].hu));
      chk("v_tens", 32'(tens), 32'(vecs[i].te));
      chk("v_ones", 32'(ones), 32'(vecs[i].on));
      chk("v_seg_ones", 32'(d_ones), 32'(vecs[i].seg_on));
      chk("v_seg_thou", 32'(d_thou), 32'(vecs[i].seg_th));
    end

    // Reach the sentinel and watch PC for several cycles
    @(negedge clk);
    n++;
    chk("sent_pc", current_pc, 32'h28);
    chk("sent_instr", instr, SENT);
    repeat (6) begin
      @(negedge clk);
      n++;
      check_step(n);
    end

    // Random run lengths with mid-cycle async resets
    repeat (10) begin
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      chk("async_pc", current_pc, 32'h0);
      chk("async_instr", instr, ROM0);
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_pc", current_pc, 32'h0);
        chk("hold_final", final_out, 32'd5);
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      len = $urandom_range(1, 18);
      for (int k = 0; k < int'(len); k++) begin
        check_step(n);
        @(negedge clk);
        n++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
